// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-divide step on {acc, sh}.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] sh,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] sh_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN-1:0] diff;
    logic          ge;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, b};
        part    = {acc, sh[XLEN-1]};
        // The trial result always fits in XLEN bits whenever the subtract succeeds.
        ge      = (part >= {1'b0, b});
        diff    = part[XLEN-1:0] - b;
        acc_nxt = acc;
        sh_nxt  = sh;
        if (is_div) begin
            if (ge) begin
                acc_nxt = diff;
                sh_nxt  = {sh[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = part[XLEN-1:0];
                sh_nxt  = {sh[XLEN-2:0], 1'b0};
            end
        end else begin
            if (sh[0]) begin
                acc_nxt = sum[XLEN:1];
                sh_nxt  = {sum[0], sh[XLEN-1:1]};
            end else begin
                acc_nxt = {1'b0, acc[XLEN-1:1]};
                sh_nxt  = {acc[0], sh[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers: FSM, iteration counter,
// sign fix-up and MTHI/MTLO writes. Fixed 34-cycle latency from accept to result.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(MDU_ITERS);

    mdu_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            is_div;
    logic            neg_hi;
    logic            neg_lo;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] acc_nxt;
    logic [XLEN-1:0] sh_nxt;

    logic            accept;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] hi_fix;
    logic [XLEN-1:0] lo_fix;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v, input logic neg);
        logic signed [2*XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .b       (b_mag),
        .acc     (acc),
        .sh      (sh),
        .acc_nxt (acc_nxt),
        .sh_nxt  (sh_nxt)
    );

    always_comb begin
        accept = start && ((state == S_IDLE) || (state == S_DONE));
        sa     = op[0] & src_a[XLEN-1];
        sb     = op[0] & src_b[XLEN-1];
        mag_a  = neg_w(src_a, sa);
        mag_b  = neg_w(src_b, sb);
        if (is_div) begin
            hi_fix = neg_w(acc, neg_hi);
            lo_fix = neg_w(sh, neg_lo);
        end else begin
            {hi_fix, lo_fix} = neg_2w({acc, sh}, neg_lo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            b_mag  <= '0;
            acc    <= '0;
            sh     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (we_hi && !busy) hi <= wdata;
            if (we_lo && !busy) lo <= wdata;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state  <= S_ITER;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        acc    <= '0;
                        if (op[1]) begin
                            sh     <= mag_a;
                            b_mag  <= mag_b;
                            // Divide by zero keeps an all-ones quotient, so its sign is never applied.
                            neg_lo <= (sa ^ sb) && (src_b != '0);
                            neg_hi <= sa;
                        end else begin
                            sh     <= mag_b;
                            b_mag  <= mag_a;
                            neg_lo <= sa ^ sb;
                            neg_hi <= sa ^ sb;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MDU_ITERS - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: table of operations checked through an expected-result queue,
// plus MTHI/MTLO, mid-operation reset and back-to-back sequences.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int ncmp = 0;
    int nerr = 0;
    logic [63:0] expq[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[14];

    mdu_hilo #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drives one start at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        chk("busy_cycle1", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string nm, input int n0);
        logic [63:0] e;
        for (int n = n0; n <= 45; n++) begin
            if (n > n0) @(negedge clk);
            if (n == 33) begin
                chk({nm, "_busy_c33"}, 64'(busy), 64'd1);
                chk({nm, "_done_c33"}, 64'(done), 64'd0);
            end
            if (done) begin
                chk({nm, "_latency"}, 64'(n), 64'd34);
                chk({nm, "_busy_c34"}, 64'(busy), 64'd0);
                if (expq.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL %s_queue: got done with no expected result, required none", nm);
                end else begin
                    e = expq.pop_front();
                    chk({nm, "_hi"}, 64'(hi), 64'(e[63:32]));
                    chk({nm, "_lo"}, 64'(lo), 64'(e[31:0]));
                end
                return;
            end
        end
        ncmp++;
        nerr++;
        $display("FAIL %s_timeout: got no done within 45 cycles, required done at 34", nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] lo_before;
        int saw_done;

        vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[3]  = '{MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "divu_by0"};
        vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1m1"};
        vecs[6]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
        vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7dm2"};
        vecs[8]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_m7by0"};
        vecs[9]  = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32"};
        vecs[10] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"};
        vecs[11] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        "div_m8dm3"};
        vecs[12] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu_maxd1"};
        vecs[13] = '{MDU_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult_maxm1"};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            expq.push_back({vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, 1);
            @(negedge clk);
        end

        // MTHI while idle, MTLO dropped while busy
        we_hi = 1'b1;
        wdata = 32'h00001234;
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi_idle", 64'(hi), 64'h1234);
        lo_before = lo;
        expq.push_back({32'd2, 32'd14});
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        we_lo = 1'b1;
        wdata = 32'h00000055;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo_busy_dropped", 64'(lo), 64'(lo_before));
        wait_done("mtlo_seq", 6);
        @(negedge clk);

        // MTHI in the accept cycle lands, then the result overwrites it
        we_hi = 1'b1;
        wdata = 32'h0000ABCD;
        expq.push_back({32'h00000000, 32'h00000015});
        issue(MDU_MULTU, 32'd3, 32'd7);
        we_hi = 1'b0;
        chk("mthi_with_start", 64'(hi), 64'hABCD);
        wait_done("mthi_start_seq", 1);
        @(negedge clk);

        // Reset at cycle 10 of a DIVU
        issue(MDU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        chk("midrst_idle_busy", 64'(busy), 64'd0);

        // Back-to-back: second start issued in the DONE cycle
        expq.push_back({32'h00000000, 32'h0000000C});
        issue(MDU_MULTU, 32'd3, 32'd4);
        wait_done("b2b_first", 1);
        expq.push_back({32'd1, 32'd3});
        issue(MDU_DIVU, 32'd10, 32'd3);
        wait_done("b2b_second", 1);
        @(negedge clk);
        chk("queue_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
